capture_thresh_loader: RTL and testbench



---
 rtl/capture_thresh_loader.sv | 164 ++++++++++++++++
 tb/tb_capture_thresh_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module   : capture_thresh_loader
// Brief    : Per-channel threshold table loaded from the load_thresh register,
//            with single-channel writes, broadcast sweeps and 2-cycle lookups.
//            Optional macro THRESH_INIT_SWEEP_EN: fill the table with 0x7FFF
//            right after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module capture_thresh_loader (
    input  logic        user_clk,
    input  logic        user_rst_n,
    input  logic [31:0] reg_data,
    input  logic        ch_valid,
    input  logic [7:0]  ch_idx,
    output logic        thresh_valid,
    output logic [15:0] thresh_out,
    output logic        busy,
    output logic        overrun,
    output logic [15:0] load_count
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_SWEEP = 2'd2;

`ifdef THRESH_INIT_SWEEP_EN
    localparam logic C_INIT_EN = 1'b1;
`else
    localparam logic C_INIT_EN = 1'b0;
`endif

    logic [31:0] reg_q;
    logic        strb_prev_q;
    logic [1:0]  arm_q;
    logic [1:0]  state_q,     state_d;
    logic [7:0]  ch_q,        ch_d;
    logic [15:0] thr_q,       thr_d;
    logic [7:0]  addr_q,      addr_d;
    logic        init_q,      init_d;
    logic        init_pend_q, init_pend_d;
    logic [15:0] count_q,     count_d;
    logic        overrun_q,   overrun_d;
    logic        rd_valid_q;
    logic [15:0] rd_data_q;
    logic        thresh_valid_q;
    logic [15:0] thresh_out_q;
    logic [15:0] mem_q [0:255];

    logic        w_edge;
    logic        w_we;
    logic [7:0]  w_waddr;
    logic        w_unused_bits;

    assign w_unused_bits = ^{reg_q[29:28], reg_q[19:16]};

    // arm_q[1] only rises once reg_q and its history both hold post-reset
    // samples, so a strobe already high at reset release is never an edge.
    assign w_edge = reg_q[31] & ~strb_prev_q & arm_q[1];

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        thr_d       = thr_q;
        addr_d      = addr_q;
        init_d      = init_q;
        init_pend_d = init_pend_q;
        count_d     = count_q;
        overrun_d   = overrun_q | (w_edge & (state_q != ST_IDLE));
        w_we        = 1'b0;
        w_waddr     = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (init_pend_q) begin
                    state_d     = ST_SWEEP;
                    addr_d      = 8'd0;
                    thr_d       = 16'h7FFF;
                    init_d      = 1'b1;
                    init_pend_d = 1'b0;
                end else if (w_edge) begin
                    thr_d = reg_q[15:0];
                    if (reg_q[30]) begin
                        state_d = ST_SWEEP;
                        addr_d  = 8'd0;
                        init_d  = 1'b0;
                    end else begin
                        state_d = ST_WRITE;
                        ch_d    = reg_q[27:20];
                    end
                end
            end
            ST_WRITE: begin
                w_we    = 1'b1;
                w_waddr = ch_q;
                count_d = count_q + 16'd1;
                state_d = ST_IDLE;
            end
            ST_SWEEP: begin
                w_we    = 1'b1;
                w_waddr = addr_q;
                addr_d  = addr_q + 8'd1;
                if (addr_q == 8'hFF) begin
                    state_d = ST_IDLE;
                    if (!init_q) begin
                        count_d = count_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            reg_q          <= 32'd0;
            strb_prev_q    <= 1'b0;
            arm_q          <= 2'b00;
            state_q        <= ST_IDLE;
            ch_q           <= 8'd0;
            thr_q          <= 16'd0;
            addr_q         <= 8'd0;
            init_q         <= 1'b0;
            init_pend_q    <= C_INIT_EN;
            count_q        <= 16'd0;
            overrun_q      <= 1'b0;
            rd_valid_q     <= 1'b0;
            thresh_valid_q <= 1'b0;
            thresh_out_q   <= 16'd0;
        end else begin
            reg_q          <= reg_data;
            strb_prev_q    <= reg_q[31];
            arm_q          <= {arm_q[0], 1'b1};
            state_q        <= state_d;
            ch_q           <= ch_d;
            thr_q          <= thr_d;
            addr_q         <= addr_d;
            init_q         <= init_d;
            init_pend_q    <= init_pend_d;
            count_q        <= count_d;
            overrun_q      <= overrun_d;
            rd_valid_q     <= ch_valid;
            thresh_valid_q <= rd_valid_q;
            if (rd_valid_q) begin
                thresh_out_q <= rd_data_q;
            end
        end
    end

    // Table is deliberately not reset; read and write share an edge so a
    // same-cycle lookup sees the pre-write contents.
    always_ff @(posedge user_clk) begin
        if (w_we) begin
            mem_q[w_waddr] <= thr_q;
        end
        rd_data_q <= mem_q[ch_idx];
    end

    assign thresh_valid = thresh_valid_q;
    assign thresh_out   = thresh_out_q;
    assign busy         = (state_q == ST_SWEEP);
    assign overrun      = overrun_q;
    assign load_count   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_thresh_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_capture_thresh_loader
// Brief    : Randomized self-checking bench for capture_thresh_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_capture_thresh_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] reg_data;
    logic        ch_valid;
    logic [7:0]  ch_idx;
    logic        thresh_valid;
    logic [15:0] thresh_out;
    logic        busy;
    logic        overrun;
    logic [15:0] load_count;

    int vectors = 0;
    int errors  = 0;

    logic [15:0] model_tbl [256];
    bit          model_known [256];
    logic [15:0] model_count;

    always #5 clk = ~clk;

    capture_thresh_loader dut (
        .user_clk     (clk),
        .user_rst_n   (rst_n),
        .reg_data     (reg_data),
        .ch_valid     (ch_valid),
        .ch_idx       (ch_idx),
        .thresh_valid (thresh_valid),
        .thresh_out   (thresh_out),
        .busy         (busy),
        .overrun      (overrun),
        .load_count   (load_count)
    );

    task automatic present(input bit strobe, input bit bcast, input logic [7:0] ch, input logic [15:0] val);
        reg_data = {strobe, bcast, 2'b00, ch, 4'h0, val};
        @(negedge clk);
    endtask

    task automatic do_write(input logic [7:0] ch, input logic [15:0] val);
        present(1'b0, 1'b0, ch, val);
        present(1'b1, 1'b0, ch, val);
        repeat (3) @(negedge clk);
        present(1'b0, 1'b0, ch, val);
    endtask

    task automatic lookup(input logic [7:0] idx, output bit v1, output bit v2, output logic [15:0] dout);
        ch_valid = 1'b1;
        ch_idx   = idx;
        @(negedge clk);
        ch_valid = 1'b0;
        v1 = thresh_valid;
        @(negedge clk);
        v2   = thresh_valid;
        dout = thresh_out;
    endtask

    task automatic wait_busy_rise(output bit timeout);
        int n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        timeout = !busy;
    endtask

    task automatic count_busy(output int hi);
        hi = 0;
        while (busy && hi < 400) begin
            hi++;
            @(negedge clk);
        end
    endtask

    task automatic fill_model(input logic [15:0] val);
        for (int i = 0; i < 256; i++) begin
            model_tbl[i]   = val;
            model_known[i] = 1'b1;
        end
    endtask

    task automatic test_reset;
        bit to;
        int hi;
        rst_n = 1'b0; reg_data = '0; ch_valid = 1'b0; ch_idx = '0;
        model_count = 16'd0;
        repeat (3) @(negedge clk);
        vectors++; if (thresh_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", thresh_valid); end
        vectors++; if (thresh_out !== 16'h0) begin errors++; $display("FAIL reset_out: got %h expected 0000", thresh_out); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vectors++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        vectors++; if (load_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %h expected 0000", load_count); end
        rst_n = 1'b1;
`ifdef THRESH_INIT_SWEEP_EN
        wait_busy_rise(to);
        vectors++; if (to) begin errors++; $display("FAIL init_busy_rise: got timeout expected busy"); end
        count_busy(hi);
        vectors++; if (hi != 256) begin errors++; $display("FAIL init_busy_len: got %0d expected 256", hi); end
        fill_model(16'h7FFF);
        for (int i = 0; i < 256; i += 51) begin
            bit v1, v2; logic [15:0] d;
            lookup(i[7:0], v1, v2, d);
            vectors++; if (d !== 16'h7FFF || !v2) begin errors++; $display("FAIL init_value ch%0d: got %h expected 7fff", i, d); end
        end
        vectors++; if (load_count !== 16'h0) begin errors++; $display("FAIL init_count: got %h expected 0000", load_count); end
`else
        hi = 0;
        repeat (8) begin
            @(negedge clk);
            if (busy) hi++;
        end
        to = 1'b0;
        vectors++; if (hi != 0 || to) begin errors++; $display("FAIL idle_after_reset: got %0d busy cycles expected 0", hi); end
`endif
    endtask

    task automatic test_single_load;
        bit v1, v2; logic [15:0] d;
        reg_data = 32'h0000_0000;
        @(negedge clk);
        reg_data = 32'h8050_0123;
        repeat (5) @(negedge clk);
        model_tbl[5] = 16'h0123; model_known[5] = 1'b1; model_count++;
        lookup(8'd5, v1, v2, d);
        vectors++; if (v1 !== 1'b0) begin errors++; $display("FAIL single_latency1: got %b expected 0", v1); end
        vectors++; if (v2 !== 1'b1) begin errors++; $display("FAIL single_latency2: got %b expected 1", v2); end
        vectors++; if (d !== 16'h0123) begin errors++; $display("FAIL single_value: got %h expected 0123", d); end
        vectors++; if (load_count !== model_count) begin errors++; $display("FAIL single_count: got %h expected %h", load_count, model_count); end
        @(negedge clk);
        vectors++; if (thresh_valid !== 1'b0 || thresh_out !== 16'h0123) begin
            errors++; $display("FAIL hold_out: got v=%b %h expected v=0 0123", thresh_valid, thresh_out); end
        reg_data = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_random_loads;
        for (int k = 0; k < 16; k++) begin
            logic [7:0] ch, q; logic [15:0] val, d; bit v1, v2;
            ch  = 8'($urandom_range(0, 255));
            val = 16'($urandom);
            do_write(ch, val);
            model_tbl[ch] = val; model_known[ch] = 1'b1; model_count++;
            q = ch;
            if ((k % 2) == 1) begin
                for (int t = 0; t < 8; t++) begin
                    logic [7:0] c = 8'($urandom_range(0, 255));
                    if (model_known[c]) q = c;
                end
            end
            lookup(q, v1, v2, d);
            vectors++; if (!v2 || d !== model_tbl[q]) begin
                errors++; $display("FAIL rand_lookup ch%0d: got v=%b %h expected v=1 %h", q, v2, d, model_tbl[q]); end
        end
        vectors++; if (load_count !== model_count) begin errors++; $display("FAIL rand_count: got %h expected %h", load_count, model_count); end
    endtask

    task automatic test_broadcast;
        bit to, v1, v2; int hi; logic [15:0] d;
        logic [7:0] chs [7];
        chs = '{8'd0, 8'd127, 8'd255, 8'd1, 8'd64, 8'd200, 8'd254};
        present(1'b0, 1'b0, 8'h00, 16'hFF00);
        reg_data = 32'hC000_FF00;
        @(negedge clk);
        wait_busy_rise(to);
        vectors++; if (to) begin errors++; $display("FAIL bcast_rise: got timeout expected busy"); end
        count_busy(hi);
        vectors++; if (hi != 256) begin errors++; $display("FAIL bcast_busy_len: got %0d expected 256", hi); end
        present(1'b0, 1'b0, 8'h00, 16'h0);
        fill_model(16'hFF00); model_count++;
        for (int i = 0; i < 7; i++) begin
            lookup(chs[i], v1, v2, d);
            vectors++; if (!v2 || d !== model_tbl[chs[i]]) begin
                errors++; $display("FAIL bcast_value ch%0d: got %h expected %h", chs[i], d, model_tbl[chs[i]]); end
        end
        vectors++; if (load_count !== model_count) begin errors++; $display("FAIL bcast_count: got %h expected %h", load_count, model_count); end
    endtask

    task automatic test_collision;
        bit v1, v2; logic [15:0] old_v;
        old_v = 16'($urandom_range(16'h100, 16'hFFFF));
        do_write(8'd9, old_v);
        model_tbl[9] = old_v; model_count++;
        present(1'b1, 1'b0, 8'd9, 16'h0042);
        @(negedge clk);
        // now in the WRITE cycle for ch 9
        ch_valid = 1'b1; ch_idx = 8'd9;
        @(negedge clk);
        @(negedge clk);
        ch_valid = 1'b0;
        vectors++; if (thresh_valid !== 1'b1 || thresh_out !== old_v) begin
            errors++; $display("FAIL collide_same_cycle: got v=%b %h expected v=1 %h", thresh_valid, thresh_out, old_v); end
        @(negedge clk);
        vectors++; if (thresh_valid !== 1'b1 || thresh_out !== 16'h0042) begin
            errors++; $display("FAIL collide_next_cycle: got v=%b %h expected v=1 0042", thresh_valid, thresh_out); end
        model_tbl[9] = 16'h0042; model_count++;
        present(1'b0, 1'b0, 8'd9, 16'h0);
        vectors++; if (load_count !== model_count) begin errors++; $display("FAIL collide_count: got %h expected %h", load_count, model_count); end
    endtask

    task automatic test_overrun;
        bit to, v1, v2; int hi; logic [15:0] bv, xv, d; logic [7:0] xc;
        bv = 16'($urandom); xv = ~bv; xc = 8'($urandom_range(1, 254));
        present(1'b0, 1'b1, 8'h0, bv);
        present(1'b1, 1'b1, 8'h0, bv);
        wait_busy_rise(to);
        vectors++; if (to) begin errors++; $display("FAIL ovr_rise: got timeout expected busy"); end
        present(1'b0, 1'b0, xc, xv);
        present(1'b1, 1'b0, xc, xv);
        count_busy(hi);
        present(1'b0, 1'b0, xc, xv);
        repeat (3) @(negedge clk);
        fill_model(bv); model_count++;
        lookup(xc, v1, v2, d);
        vectors++; if (d !== bv) begin errors++; $display("FAIL ovr_no_write: got %h expected %h", d, bv); end
        vectors++; if (load_count !== model_count) begin errors++; $display("FAIL ovr_count: got %h expected %h", load_count, model_count); end
        vectors++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        do_write(8'd3, 16'h1234);
        model_tbl[3] = 16'h1234; model_count++;
        vectors++; if (overrun !== 1'b1 || load_count !== model_count) begin
            errors++; $display("FAIL ovr_sticky: got ovr=%b cnt=%h expected ovr=1 cnt=%h", overrun, load_count, model_count); end
    endtask

    task automatic test_reset_mid_sweep;
        bit to, v1, v2; int hi; logic [15:0] nv, d;
        logic [7:0] chs [6];
        chs = '{8'd0, 8'd50, 8'd99, 8'd100, 8'd101, 8'd255};
        nv = 16'($urandom);
        if (nv == model_tbl[100]) nv = ~nv;
        present(1'b0, 1'b1, 8'h0, nv);
        present(1'b1, 1'b1, 8'h0, nv);
        wait_busy_rise(to);
        vectors++; if (to) begin errors++; $display("FAIL rst_sweep_rise: got timeout expected busy"); end
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if ({thresh_valid, busy, overrun} !== 3'b000 || thresh_out !== 16'h0 || load_count !== 16'h0) begin
            errors++; $display("FAIL rst_async: got v=%b b=%b o=%b out=%h cnt=%h expected all 0",
                               thresh_valid, busy, overrun, thresh_out, load_count); end
        for (int i = 0; i < 100; i++) model_tbl[i] = nv;
        model_count = 16'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
`ifdef THRESH_INIT_SWEEP_EN
        wait_busy_rise(to);
        count_busy(hi);
        fill_model(16'h7FFF);
        vectors++; if (hi != 256) begin errors++; $display("FAIL rst_init_len: got %0d expected 256", hi); end
`else
        hi = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy) hi++;
        end
        vectors++; if (hi != 0) begin errors++; $display("FAIL rst_strobe_held: got %0d busy cycles expected 0", hi); end
`endif
        vectors++; if (load_count !== model_count) begin errors++; $display("FAIL rst_no_load: got %h expected %h", load_count, model_count); end
        for (int i = 0; i < 6; i++) begin
            lookup(chs[i], v1, v2, d);
            vectors++; if (!v2 || d !== model_tbl[chs[i]]) begin
                errors++; $display("FAIL rst_keep ch%0d: got %h expected %h", chs[i], d, model_tbl[chs[i]]); end
        end
        present(1'b0, 1'b0, 8'h0, 16'h0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_tbl[i] = 16'h0; model_known[i] = 1'b0;
        end
        test_reset;
        test_single_load;
        test_random_loads;
        test_broadcast;
        test_collision;
        test_overrun;
        test_reset_mid_sweep;
        test_random_loads;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
